// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared execute-stage types for the multiply/divide unit
package cpu_types_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  localparam int MDU_WIDTH   = 32;
  localparam int MDU_LATENCY = MDU_WIDTH + 2;

  function automatic logic mdu_is_div(input mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_signed(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_negate.sv
// rtl/mdu_negate.sv - conditional two's-complement negation of a W-bit vector
module mdu_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? ({W{1'b0}} - i_val) : i_val;

endmodule

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative shift-add multiply / restoring divide unit
module mdu_iterative
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  mdu_state_t         r_state;
  mdu_state_t         w_next;
  mdu_op_t            r_op;
  logic [WIDTH-1:0]   r_m;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign_q;
  logic               r_sign_r;
  logic               r_dbz_pend;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_dbz;

  mdu_op_t            w_op;
  logic               w_signed_in;
  logic               w_div_in;
  logic               w_b_zero;
  logic               w_accept;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_trial;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_op        = mdu_op_t'(op);
  assign w_signed_in = mdu_is_signed(w_op);
  assign w_div_in    = mdu_is_div(w_op);
  assign w_b_zero    = (portB == {WIDTH{1'b0}});
  assign w_accept    = (r_state == IDLE) && start && !flush;

  mdu_negate #(.W(WIDTH)) u_abs_a (
    .i_val(portA), .i_neg(w_signed_in & portA[WIDTH-1]), .o_val(w_abs_a)
  );
  mdu_negate #(.W(WIDTH)) u_abs_b (
    .i_val(portB), .i_neg(w_signed_in & portB[WIDTH-1]), .o_val(w_abs_b)
  );

  // Multiply: the add carry is shifted back into the accumulator MSB.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_m};
  assign w_mul_next = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

  // Divide: rem < divisor before the shift, so a kept difference fits WIDTH bits.
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge       = (w_rem_sh >= {1'b0, r_m});
  assign w_trial    = w_rem_sh[WIDTH-1:0] - r_m;
  assign w_div_next = w_ge ? {w_trial, r_acc[WIDTH-2:0], 1'b1}
                           : {r_acc[2*WIDTH-2:0], 1'b0};

  mdu_negate #(.W(2*WIDTH)) u_fix_prod (
    .i_val(r_acc), .i_neg((r_op == MDU_MULT) & r_sign_q), .o_val(w_prod)
  );
  mdu_negate #(.W(WIDTH)) u_fix_quot (
    .i_val(r_acc[WIDTH-1:0]), .i_neg((r_op == MDU_DIV) & r_sign_q), .o_val(w_quot)
  );
  mdu_negate #(.W(WIDTH)) u_fix_rem (
    .i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg((r_op == MDU_DIV) & r_sign_r), .o_val(w_rem)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = CALC;
      CALC: begin
        if (flush)                                w_next = IDLE;
        else if (r_dbz_pend)                      w_next = DONE;
        else if (r_cnt == CNT_W'(WIDTH - 1))      w_next = FIX;
      end
      FIX:  w_next = flush ? IDLE : DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_op       <= MDU_MULT;
      r_m        <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_dbz      <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (w_accept) begin
          r_op       <= w_op;
          r_sign_q   <= w_signed_in & (portA[WIDTH-1] ^ portB[WIDTH-1]);
          r_sign_r   <= w_signed_in & portA[WIDTH-1];
          r_dbz      <= 1'b0;
          r_cnt      <= '0;
          r_dbz_pend <= w_div_in & w_b_zero;
          r_m        <= w_div_in ? w_abs_b : w_abs_a;
          // A zero-divisor divide keeps the raw dividend for HI.
          if (w_div_in && w_b_zero) r_acc <= {{WIDTH{1'b0}}, portA};
          else if (w_div_in)        r_acc <= {{WIDTH{1'b0}}, w_abs_a};
          else                      r_acc <= {{WIDTH{1'b0}}, w_abs_b};
        end
        CALC: if (!flush) begin
          if (r_dbz_pend) begin
            r_hi  <= r_acc[WIDTH-1:0];
            r_lo  <= {WIDTH{1'b1}};
            r_dbz <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_acc <= mdu_is_div(r_op) ? w_div_next : w_mul_next;
          end
        end
        FIX: if (!flush) begin
          if (mdu_is_div(r_op)) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule
